threshold_config_sequencer: RTL and testbench
=============================================

// Module: threshold_config_sequencer
// PURPOSE
//  Initiator side of the self-trigger threshold register port (write_threshold_value / threshold_ch /
//  threshold_value / threshold_value_read) on the 40-channel HPF pedestal-recovery trigger block.
//  Holds a host-written shadow table of 40 signed thresholds, then on command streams them into the
//  trigger block and optionally reads each back to verify. Sits between the slow-control register
//  file and the filter/trigger block, on the same clock as the filter block.
// PARAMETERS
//  NUM_CH      40      channels sequenced (0..NUM_CH-1), NUM_CH <= 64
//  READ_LAT    1       responder read-register stages; readback hold = READ_LAT+1 cycles per channel
//  DEF_THR     99999   shadow reset value; equals the trigger block's own reset threshold
// PORTS
//  clk                    in   1   system clock
//  reset_n                in   1   asynchronous, active-low reset
//  host_we                in   1   shadow write strobe
//  host_addr              in   6   shadow channel index
//  host_data              in   32  signed threshold to store
//  start                  in   1   one-cycle pulse: begin write (+ verify) sequence
//  verify_en              in   1   sampled at start; 1 = run readback phase after writes
//  write_threshold_value  out  1   to trigger block: write strobe
//  threshold_ch           out  8   to trigger block: channel index ({2'b0, ch})
//  threshold_value        out  32  to trigger block: signed threshold
//  threshold_value_read   in   32  from trigger block: registered readback
//  busy                   out  1   high from cycle after start until done
//  done                   out  1   one-cycle pulse at end of sequence
//  verify_err             out  1   sticky: at least one readback mismatch in last sequence
//  err_count              out  7   mismatches in last sequence (saturates at 127)
//  first_err_ch           out  6   lowest-index mismatching channel (valid when verify_err)
//  host_drop              out  1   sticky: a host write was dropped while busy
// BEHAVIOUR
//  Reset (async assert, sync release): shadow[*]=DEF_THR; all outputs 0; state IDLE. Reset mid-sequence
//   aborts immediately; write_threshold_value falls with reset_n, no done pulse.
//  All outputs to the trigger block are registered; no combinational path from inputs.
//  Shadow: host_we in IDLE with host_addr<NUM_CH writes shadow[host_addr] next edge; host_addr>=NUM_CH
//   ignored silently; host_we while busy is dropped and sets host_drop.
//  FSM: IDLE -> WR -> (verify_en ? RD_HOLD : FIN) ; RD_HOLD -> RD_CMP -> RD_HOLD|FIN ; FIN -> IDLE.
//   IDLE: start=1 -> clear verify_err/err_count/first_err_ch/host_drop, latch verify_en, ch=0, go WR.
//   WR: one channel per cycle: write_threshold_value=1, threshold_ch=ch, threshold_value=shadow[ch];
//    after ch=NUM_CH-1, strobe drops and ch resets to 0. Exactly NUM_CH strobe cycles, contiguous.
//   RD_HOLD: strobe=0, threshold_ch=ch held READ_LAT cycles (counter), then RD_CMP.
//   RD_CMP: threshold_ch still ch; compare threshold_value_read to shadow[ch] at end of cycle;
//    mismatch -> err_count+1 (sat), verify_err=1, first_err_ch=ch if first; ch++ or FIN at last.
//   FIN: done=1 for one cycle, busy=0 next cycle.
//  Latency start->done: 1+NUM_CH+1 cycles (no verify); 1+NUM_CH+NUM_CH*(READ_LAT+1)+1 (verify).
//   Defaults: 42 / 122 cycles.
//  start while busy ignored. start and host_we in same IDLE cycle: shadow write accepted and included.
//  Compare is full 32-bit signed equality; threshold_value never sign-manipulated.
// STRUCTURE
//  Shared package selftrig_pkg: NUM_CH, DEF_THR, state encodings (IDLE/WR/RD_HOLD/RD_CMP/FIN).
//  One sub-module: threshold_shadow_regs (NUM_CH x 32 reg array, 1 write port, async read by index).
//  Top contains FSM, ch/hold counters, error tracking.
// TESTING
//  Reset, start, verify_en=1, responder model unchanged -> 40 writes of 99999, done at cycle 122, err=0.
//  Host writes ch5=-200, ch39=1234, start -> strobe cycle for ch5 carries -200, ch39 carries 1234.
//  Responder forces ch17 readback to 0 -> verify_err=1, err_count=1, first_err_ch=17.
//  host_we during busy -> shadow unchanged, host_drop=1; cleared on next start.
//  reset_n low at WR ch=20 -> strobe low same cycle, busy=0, shadow=99999, no done.
//  start with verify_en=0 -> done at cycle 42; start pulse while busy -> no effect.

Source files
------------

// File: rtl/selftrig_pkg.sv
// Shared constants and state encoding for the self-trigger threshold sequencer.
package selftrig_pkg;
    localparam int                NUM_CH   = 40;
    localparam int                READ_LAT = 1;
    localparam logic signed [31:0] DEF_THR = 32'sd99999;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_HOLD = 3'd2,
        RD_CMP  = 3'd3,
        FIN     = 3'd4
    } state_t;
endpackage

// File: rtl/threshold_shadow_regs.sv
// Host-written shadow table of per-channel signed thresholds.
// One write port, two asynchronous read ports (compare index and next-write index).
module threshold_shadow_regs #(
    parameter int                NUM_CH  = selftrig_pkg::NUM_CH,
    parameter logic signed [31:0] DEF_THR = selftrig_pkg::DEF_THR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [5:0]  raddr_b,
    output logic [31:0] rdata_b
);
    localparam logic [5:0] LAST_CH = 6'(NUM_CH - 1);

    logic [NUM_CH-1:0][31:0] mem;

    // Out-of-range addresses are ignored on write and read back as the default.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mem <= {NUM_CH{DEF_THR}};
        else if (we && waddr <= LAST_CH)
            mem[waddr] <= wdata;
    end

    assign rdata_a = (raddr_a <= LAST_CH) ? mem[raddr_a] : DEF_THR;
    assign rdata_b = (raddr_b <= LAST_CH) ? mem[raddr_b] : DEF_THR;
endmodule

// File: rtl/threshold_config_sequencer.sv
// Streams the shadow threshold table into the trigger block's register port and
// optionally reads every channel back to verify it.
module threshold_config_sequencer #(
    parameter int                NUM_CH   = selftrig_pkg::NUM_CH,
    parameter int                READ_LAT = selftrig_pkg::READ_LAT,
    parameter logic signed [31:0] DEF_THR = selftrig_pkg::DEF_THR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_we,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_data,
    input  logic        start,
    input  logic        verify_en,
    output logic        write_threshold_value,
    output logic [7:0]  threshold_ch,
    output logic [31:0] threshold_value,
    input  logic [31:0] threshold_value_read,
    output logic        busy,
    output logic        done,
    output logic        verify_err,
    output logic [6:0]  err_count,
    output logic [5:0]  first_err_ch,
    output logic        host_drop
);
    import selftrig_pkg::*;

    localparam logic [5:0] LAST_CH   = 6'(NUM_CH - 1);
    localparam logic [7:0] HOLD_LAST = 8'(READ_LAT - 1);

    state_t      state;
    logic [5:0]  ch;
    logic [7:0]  hold_cnt;
    logic        verify_q;
    logic        shadow_we;
    logic [5:0]  nxt_idx;
    logic [31:0] cmp_val;
    logic [31:0] nxt_val;
    logic [31:0] first_val;

    assign shadow_we = host_we && (state == IDLE);
    assign nxt_idx   = (state == IDLE) ? 6'd0 : ch + 6'd1;

    threshold_shadow_regs #(
        .NUM_CH  (NUM_CH),
        .DEF_THR (DEF_THR)
    ) u_shadow (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (shadow_we),
        .waddr   (host_addr),
        .wdata   (host_data),
        .raddr_a (ch),
        .rdata_a (cmp_val),
        .raddr_b (nxt_idx),
        .rdata_b (nxt_val)
    );

    // A host write landing on the start edge must reach the first strobe.
    assign first_val = (host_we && host_addr == 6'd0) ? host_data : nxt_val;

    assign threshold_ch = {2'b00, ch};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            ch                    <= '0;
            hold_cnt              <= '0;
            verify_q              <= 1'b0;
            write_threshold_value <= 1'b0;
            threshold_value       <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            verify_err            <= 1'b0;
            err_count             <= '0;
            first_err_ch          <= '0;
            host_drop             <= 1'b0;
        end else begin
            done <= 1'b0;
            if (host_we && state != IDLE)
                host_drop <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    verify_err            <= 1'b0;
                    err_count             <= '0;
                    first_err_ch          <= '0;
                    host_drop             <= 1'b0;
                    verify_q              <= verify_en;
                    ch                    <= '0;
                    busy                  <= 1'b1;
                    write_threshold_value <= 1'b1;
                    threshold_value       <= first_val;
                    state                 <= WR;
                end
                WR: if (ch == LAST_CH) begin
                    write_threshold_value <= 1'b0;
                    ch                    <= '0;
                    hold_cnt              <= '0;
                    if (verify_q) begin
                        state <= RD_HOLD;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end else begin
                    ch              <= ch + 6'd1;
                    threshold_value <= nxt_val;
                end
                RD_HOLD: if (hold_cnt == HOLD_LAST)
                    state <= RD_CMP;
                else
                    hold_cnt <= hold_cnt + 8'd1;
                RD_CMP: begin
                    if (threshold_value_read != cmp_val) begin
                        verify_err <= 1'b1;
                        if (err_count != 7'h7f)
                            err_count <= err_count + 7'd1;
                        if (!verify_err)
                            first_err_ch <= ch;
                    end
                    if (ch == LAST_CH) begin
                        ch    <= '0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        ch       <= ch + 6'd1;
                        hold_cnt <= '0;
                        state    <= RD_HOLD;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_threshold_config_sequencer.sv
// Scoreboard bench: a reference shadow table and responder model predict every
// strobe and every done report; a monitor pops and compares as the DUT emits them.
module tb_threshold_config_sequencer;
    localparam int NUM_CH   = 40;
    localparam int READ_LAT = 1;
    localparam int DEF      = 99999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_we = 1'b0;
    logic [5:0]  host_addr = '0;
    logic [31:0] host_data = '0;
    logic        start = 1'b0;
    logic        verify_en = 1'b0;
    logic        write_threshold_value;
    logic [7:0]  threshold_ch;
    logic [31:0] threshold_value;
    logic [31:0] threshold_value_read;
    logic        busy, done, verify_err, host_drop;
    logic [6:0]  err_count;
    logic [5:0]  first_err_ch;

    always #5 clk = ~clk;

    threshold_config_sequencer dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .host_we               (host_we),
        .host_addr             (host_addr),
        .host_data             (host_data),
        .start                 (start),
        .verify_en             (verify_en),
        .write_threshold_value (write_threshold_value),
        .threshold_ch          (threshold_ch),
        .threshold_value       (threshold_value),
        .threshold_value_read  (threshold_value_read),
        .busy                  (busy),
        .done                  (done),
        .verify_err            (verify_err),
        .err_count             (err_count),
        .first_err_ch          (first_err_ch),
        .host_drop             (host_drop)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference state
    int  shadow [NUM_CH];
    bit  corrupt [64];
    int  resp_regs [64];
    bit  exp_drop;
    int  cyc = 0;
    int  done_seen = 0;
    bit  busy_chk = 0;

    typedef struct { int ch; int val; } wr_t;
    typedef struct { int start_edge; int lat; bit verr; int ecnt; int fch; } dn_t;
    wr_t wr_q [$];
    dn_t dn_q [$];

    // Trigger-block responder: stores strobed writes, registered readback.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) resp_regs[i] <= DEF;
            threshold_value_read <= '0;
        end else begin
            threshold_value_read <= corrupt[threshold_ch[5:0]] ? 32'd0 : resp_regs[threshold_ch[5:0]];
            if (write_threshold_value) resp_regs[threshold_ch[5:0]] <= threshold_value;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                chk("busy_low_after_done", busy, 0);
                busy_chk = 0;
            end
            if (reset_n && write_threshold_value) begin
                chk("strobe_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    chk("strobe_ch", threshold_ch, w.ch);
                    chk("strobe_val", $signed(threshold_value), w.val);
                end
            end
            if (reset_n && done) begin
                done_seen++;
                busy_chk = 1;
                chk("done_expected", dn_q.size() > 0, 1);
                if (dn_q.size() > 0) begin
                    d = dn_q.pop_front();
                    chk("latency", cyc - d.start_edge + 2, d.lat);
                    chk("verify_err", verify_err, d.verr);
                    chk("err_count", err_count, d.ecnt);
                    if (d.verr) chk("first_err_ch", first_err_ch, d.fch);
                    chk("host_drop", host_drop, exp_drop);
                    chk("strobes_all_seen", wr_q.size(), 0);
                    chk("busy_at_done", busy, 1);
                end
            end
        end
    end

    task automatic host_write(input int addr, input int data, input bit busy_now);
        @(negedge clk);
        host_we = 1'b1; host_addr = addr[5:0]; host_data = data;
        @(negedge clk);
        host_we = 1'b0;
        if (busy_now) exp_drop = 1;
        else if (addr < NUM_CH) shadow[addr] = data;
    endtask

    task automatic start_seq(input bit v, input bit with_w, input int waddr, input int wdata);
        dn_t d;
        int  cnt;
        @(negedge clk);
        start = 1'b1; verify_en = v;
        if (with_w) begin
            host_we = 1'b1; host_addr = waddr[5:0]; host_data = wdata;
            if (waddr < NUM_CH) shadow[waddr] = wdata;
        end
        exp_drop = 0;
        for (int c = 0; c < NUM_CH; c++) wr_q.push_back('{ch: c, val: shadow[c]});
        cnt = 0; d.fch = 0;
        if (v) for (int c = 0; c < NUM_CH; c++)
            if (corrupt[c] && shadow[c] != 0) begin
                if (cnt == 0) d.fch = c;
                cnt++;
            end
        d.start_edge = cyc + 1;
        d.lat  = v ? 1 + NUM_CH + NUM_CH * (READ_LAT + 1) + 1 : 1 + NUM_CH + 1;
        d.verr = (cnt > 0);
        d.ecnt = (cnt > 127) ? 127 : cnt;
        dn_q.push_back(d);
        @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        verify_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_seen != prev) break;
        end
        chk("done_arrived", done_seen - prev, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bit v, input bit mid_start, input bit mid_drop,
                       input bit with_w, input int waddr, input int wdata);
        int prev;
        prev = done_seen;
        start_seq(v, with_w, waddr, wdata);
        repeat (8) @(negedge clk);
        if (mid_start) begin
            start = 1'b1; verify_en = ~v;
            @(negedge clk);
            start = 1'b0;
        end
        if (mid_drop) host_write($urandom_range(0, NUM_CH - 1), int'($urandom), 1);
        wait_done(prev);
    endtask

    initial begin
        int prev, nw;
        bit found;
        for (int i = 0; i < NUM_CH; i++) shadow[i] = DEF;
        for (int i = 0; i < 64; i++) corrupt[i] = 0;
        exp_drop = 0;

        repeat (3) @(negedge clk);
        chk("rst_strobe", write_threshold_value, 0);
        chk("rst_ch", threshold_ch, 0);
        chk("rst_value", threshold_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_verify_err", verify_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_ch", first_err_ch, 0);
        chk("rst_host_drop", host_drop, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Default table, verified
        run(1, 0, 0, 0, 0, 0);
        // Directed host writes, out-of-range address ignored
        host_write(5, -200, 0);
        host_write(39, 1234, 0);
        host_write(45, 777, 0);
        run(0, 0, 0, 0, 0, 0);
        // Corrupted readback on ch17
        corrupt[17] = 1;
        run(1, 0, 0, 0, 0, 0);
        corrupt[17] = 0;
        // Host write while busy is dropped, then cleared on next start
        run(0, 0, 1, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0);
        // Start pulse while busy has no effect
        run(0, 1, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 0);
        // Host write in the start cycle is included
        run(0, 0, 0, 1, 0, -5);
        run(1, 0, 0, 1, 39, 42);

        // Reset in the middle of the write burst
        prev = done_seen;
        start_seq(0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (write_threshold_value && threshold_ch == 8'd20) begin found = 1; break; end
        end
        chk("reached_ch20", found, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_strobe", write_threshold_value, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        wr_q.delete();
        dn_q.delete();
        for (int i = 0; i < NUM_CH; i++) shadow[i] = DEF;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(posedge clk);
        chk("no_done_after_abort", done_seen - prev, 0);
        @(negedge clk);
        run(1, 0, 0, 0, 0, 0);

        // Randomized sequences
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(3, 6);
            for (int k = 0; k < nw; k++)
                host_write($urandom_range(0, 47), ($urandom_range(0, 4) == 0) ? 0 : int'($urandom), 0);
            for (int k = 0; k < 64; k++) corrupt[k] = 0;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) corrupt[$urandom_range(0, NUM_CH - 1)] = 1;
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, NUM_CH - 1), int'($urandom));
        end
        for (int k = 0; k < 64; k++) corrupt[k] = 0;

        repeat (5) @(negedge clk);
        chk("queues_drained", wr_q.size() + dn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
